// File: rtl/reg_ser_pkg.sv
// Shared types and default sizing for the register-path serializer.
package reg_ser_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_BIT_CYCLES = 1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick marks the last enabled cycle of each bit while run is high.
module bit_timer
  import reg_ser_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst_,
  input  logic enable,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;

  logic [CW-1:0] cnt;

  assign tick = run && enable && (cnt == CW'(BIT_CYCLES - 1));

  // Count restarts at every bit boundary and stays parked at zero between frames.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (enable) begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready intake and a global stall enable.
module reg_serializer
  import reg_ser_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);

  ser_state_t       state, state_next;
  logic [WIDTH-1:0] shreg, shifted;
  logic [BW-1:0]    bit_cnt;
  logic             tick, accept, last_bit, running;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign ready    = (state == IDLE) && enable && rst_;
  assign accept   = valid && ready;
  assign running  = (state == SHIFT);
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign shifted  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_  (rst_),
    .enable(enable),
    .run   (running),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (tick && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is cleared unconditionally so it stays a single pulse even under a stall.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sout    <= 1'b0;
      sframe  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg   <= data;
        sout    <= lead_bit(data);
        sframe  <= 1'b1;
        bit_cnt <= '0;
      end else if (tick) begin
        shreg <= shifted;
        if (last_bit) begin
          sout    <= 1'b0;
          sframe  <= 1'b0;
          done    <= 1'b1;
          bit_cnt <= '0;
        end else begin
          sout    <= lead_bit(shifted);
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_serializer.sv
// Randomized self-checking bench: dut_a uses defaults, dut_b is LSB-first with 3-cycle bits.
module tb_reg_serializer;

  logic       clk = 1'b0;
  logic       rst_;
  logic       en  [2];
  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy [2];
  logic       so  [2];
  logic       sf  [2];
  logic       dn  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_serializer dut_a (
    .clk   (clk),
    .rst_  (rst_),
    .enable(en[0]),
    .data  (dat[0]),
    .valid (vld[0]),
    .ready (rdy[0]),
    .sout  (so[0]),
    .sframe(sf[0]),
    .done  (dn[0])
  );

  reg_serializer #(
    .WIDTH     (8),
    .BIT_CYCLES(3),
    .MSB_FIRST (1'b0)
  ) dut_b (
    .clk   (clk),
    .rst_  (rst_),
    .enable(en[1]),
    .data  (dat[1]),
    .valid (vld[1]),
    .ready (rdy[1]),
    .sout  (so[1]),
    .sframe(sf[1]),
    .done  (dn[1])
  );

  // Offers word, then follows the frame by counting enabled cycles p; expected bit is word bit p/B.
  task automatic send_frame(input int d, input logic [7:0] word, input int stall_at,
                            input int stall_len, input bit rand_stall, input bit hold,
                            input logic [7:0] next_word, output int frame_cycles);
    int   b, total, p, stalled, guard;
    bit   msb;
    logic exp_bit, en_next;
    b = (d == 0) ? 1 : 3;
    msb = (d == 0);
    total = 8 * b;
    p = 0;
    stalled = 0;
    guard = 0;
    frame_cycles = 0;
    dat[d] = word;
    vld[d] = 1'b1;
    en[d]  = 1'b1;
    #1;
    tests++;
    if (rdy[d] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_idle dut%0d: got %b want 1", d, rdy[d]);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      dat[d] = next_word;
    end else begin
      vld[d] = 1'b0;
      dat[d] = ~word;
    end
    forever begin
      @(negedge clk);
      if (p < total) begin
        exp_bit = msb ? word[7 - p / b] : word[p / b];
        frame_cycles++;
        tests++;
        if (so[d] !== exp_bit || sf[d] !== 1'b1 || dn[d] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL frame_bit dut%0d word=%h p=%0d: sout/sframe/done got %b%b%b want %b10",
                   d, word, p, so[d], sf[d], dn[d], exp_bit);
        end
        tests++;
        if (rdy[d] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL busy_ready dut%0d p=%0d: got %b want 0", d, p, rdy[d]);
        end
      end else begin
        tests++;
        if (so[d] !== 1'b0 || sf[d] !== 1'b0 || dn[d] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL done_cycle dut%0d word=%h: sout/sframe/done got %b%b%b want 001",
                   d, word, so[d], sf[d], dn[d]);
        end
        tests++;
        if (rdy[d] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL ready_at_done dut%0d: got %b want 1", d, rdy[d]);
        end
        break;
      end
      guard++;
      if (guard > 400) begin
        tests++;
        fails++;
        $display("[TB] FAIL frame_timeout dut%0d: got p=%0d want %0d", d, p, total);
        en[d] = 1'b1;
        break;
      end
      en_next = 1'b1;
      if (rand_stall && $urandom_range(0, 3) == 0) en_next = 1'b0;
      if (p == stall_at && stalled < stall_len) begin
        en_next = 1'b0;
        stalled++;
      end
      en[d] = en_next;
      @(posedge clk);
      if (en_next) p++;
    end
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (so[d] !== 1'b0 || sf[d] !== 1'b0 || dn[d] !== 1'b0 || rdy[d] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_outputs dut%0d: sout/sframe/done/ready got %b%b%b%b want 0000",
                 d, so[d], sf[d], dn[d], rdy[d]);
      end
    end
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rdy[d] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ready_after_reset dut%0d: got %b want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_msb_basic;
    int fc;
    @(negedge clk);
    send_frame(0, 8'h05, -1, 0, 1'b0, 1'b0, 8'h00, fc);
    tests++;
    if (fc !== 8) begin
      fails++;
      $display("[TB] FAIL msb_frame_len: got %0d want 8", fc);
    end
  endtask

  task automatic test_lsb_slow;
    int fc;
    @(negedge clk);
    send_frame(1, 8'hA0, -1, 0, 1'b0, 1'b0, 8'h00, fc);
    tests++;
    if (fc !== 24) begin
      fails++;
      $display("[TB] FAIL lsb_frame_len: got %0d want 24", fc);
    end
  endtask

  task automatic test_stall;
    int fc;
    @(negedge clk);
    send_frame(0, 8'hF0, 2, 4, 1'b0, 1'b0, 8'h00, fc);
    tests++;
    if (fc !== 12) begin
      fails++;
      $display("[TB] FAIL stall_frame_len: got %0d want 12", fc);
    end
  endtask

  task automatic test_back_to_back;
    int fc;
    @(negedge clk);
    send_frame(0, 8'hC3, -1, 0, 1'b0, 1'b1, 8'h3C, fc);
    send_frame(0, 8'h3C, -1, 0, 1'b0, 1'b0, 8'h00, fc);
    tests++;
    if (fc !== 8) begin
      fails++;
      $display("[TB] FAIL b2b_frame_len: got %0d want 8", fc);
    end
  endtask

  task automatic test_done_stall;
    int fc;
    @(negedge clk);
    send_frame(0, 8'h81, -1, 0, 1'b0, 1'b0, 8'h00, fc);
    en[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (dn[0] !== 1'b0 || sf[0] !== 1'b0 || rdy[0] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL done_under_stall cyc=%0d: done/sframe/ready got %b%b%b want 000",
                 i, dn[0], sf[0], rdy[0]);
      end
    end
    en[0] = 1'b1;
  endtask

  task automatic test_idle_disabled;
    int fc;
    @(negedge clk);
    en[0]  = 1'b0;
    vld[0] = 1'b1;
    dat[0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (rdy[0] !== 1'b0 || sf[0] !== 1'b0 || dn[0] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL idle_disabled cyc=%0d: ready/sframe/done got %b%b%b want 000",
                 i, rdy[0], sf[0], dn[0]);
      end
    end
    send_frame(0, 8'h5A, -1, 0, 1'b0, 1'b0, 8'h00, fc);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    dat[0] = 8'hFF;
    vld[0] = 1'b1;
    en[0]  = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (so[0] !== 1'b1 || sf[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_bit4: sout/sframe got %b%b want 11", so[0], sf[0]);
    end
    rst_ = 1'b0;
    #1;
    tests++;
    if (so[0] !== 1'b0 || sf[0] !== 1'b0 || dn[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_immediate: sout/sframe/done/ready got %b%b%b%b want 0000",
               so[0], sf[0], dn[0], rdy[0]);
    end
    #1;
    rst_ = 1'b1;
    #1;
    tests++;
    if (rdy[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_ready: got %b want 1", rdy[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (dn[0] !== 1'b0 || sf[0] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL abort_no_done cyc=%0d: done/sframe got %b%b want 00", i, dn[0], sf[0]);
      end
    end
  endtask

  task automatic test_random;
    int         fc, d;
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      d = i % 2;
      w = 8'($urandom);
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_frame(d, w, -1, 0, 1'b1, 1'b0, 8'h00, fc);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d]  = 1'b1;
      vld[d] = 1'b0;
      dat[d] = 8'h00;
    end
    test_reset;
    test_msb_basic;
    test_lsb_slow;
    test_stall;
    test_back_to_back;
    test_done_stall;
    test_idle_disabled;
    test_reset_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
Parallel-in, serial-out transmitter for the 8-bit enable-gated data register path.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time on sout.
- sframe marks the active frame.
- Shares the global enable so the whole link can be stalled in place.
- It is the transmit end; the downstream deserializer/register captures sout while sframe=1.

Parameters:
WIDTH, 8, word width in bits (>=2)
BIT_CYCLES, 1, clock cycles each bit is held on sout (>=1)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first

Ports:
clk  input  1  system clock, rising-edge
rst_  input  1  reset, asynchronous, active-low
enable  input  1  global advance enable; 0 stalls the block
data  input  WIDTH  parallel word, sampled only at acceptance
valid  input  1  upstream has a word on data
ready  output  1  block can accept a word this cycle
sout  output  1  serial data out (registered)
sframe  output  1  high while a frame's bits are on sout (registered)
done  output  1  one-cycle pulse after the last bit of a frame (registered)

Behaviour:
- Interface: one clock, clk; reset rst_ is asynchronous, active-low.
- Reset (rst_=0, asynchronous):
  - state=IDLE; shift register=0; bit counter=0; cycle counter=0.
  - sout=0, sframe=0, done=0.
- ready is combinational: ready = (state==IDLE) && enable && rst_.
- Acceptance: a rising edge with valid=1 and ready=1. data is copied into the shift register; state becomes SHIFT.
- No acceptance while ready=0. Upstream must hold valid and data until accepted. data changes after acceptance have no effect.
- States:
  - IDLE -> SHIFT on acceptance.
  - SHIFT -> IDLE when the last bit's final cycle completes with enable=1.
- Timing, acceptance at edge E0 with B=BIT_CYCLES:
  - Bit k (k=0..WIDTH-1) is on sout, with sframe=1, for B cycles starting after edge E0+k*B.
  - After edge E0+WIDTH*B: sframe=0, sout=0, done=1 for exactly one cycle, state=IDLE.
- Bit order:
  - MSB_FIRST=1: shift left, sout = shreg[WIDTH-1].
  - MSB_FIRST=0: shift right, sout = shreg[0].
- Back-to-back: a new word can be accepted at the edge ending the done cycle. Minimum gap between frames is one idle cycle (sframe=0).
- enable=0:
  - All state, counters, the shift register, sout and sframe hold their values; ready=0.
  - A stall during SHIFT stretches the current bit.
  - If enable falls while done=1, done still drops after one cycle. done never repeats.
- enable=0 in IDLE: valid is ignored.
- rst_ asserted mid-frame aborts immediately. Outputs go to reset values and no done is generated.
- Counters: bit counter is $clog2(WIDTH) bits; cycle counter is $clog2(BIT_CYCLES)+1 bits. Both wrap to 0 on each bit/frame boundary.

Decomposition:
- Package reg_ser_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t
  - default constants DEF_WIDTH=8 and DEF_BIT_CYCLES=1
- One natural sub-module, bit_timer:
  - Parameter BIT_CYCLES; inputs clk, rst_, enable, run.
  - Output tick: high on the last enabled cycle of each bit period.
  - reg_serializer advances the shift register and bit counter on tick.

Test Plan:
- Defaults, data=8'h05, valid=1 for one accepted edge, enable=1 -> sout = 0,0,0,0,0,1,0,1 on 8 consecutive cycles with sframe=1; done=1 on cycle 9; ready=1 again on cycle 9.
- MSB_FIRST=0, BIT_CYCLES=3, data=8'hA0 -> sout 0 for 15 cycles, then 1 (3), 0 (3), 1 (3); sframe high 24 cycles; single done pulse.
- Mid-frame stall: data=8'hF0, enable=0 for 4 cycles after bit 2 -> bit 2 (value 1) held 5 cycles total; frame lasts 12 cycles; sequence otherwise unchanged.
- valid held high and data changed to 8'h3C during a frame of 8'hC3 -> transmitted bits are 8'hC3; 8'h3C accepted at the done edge and sent next, after exactly one sframe=0 cycle.
- rst_ pulsed low 2 ns during bit 4 of 8'hFF -> sout=0, sframe=0, done=0 immediately; no done; ready=1 after rst_ rises.
- enable=0 with valid=1 in IDLE for 5 cycles -> no acceptance, ready=0, sframe=0; acceptance on the first edge after enable=1.
